// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST output-response analyzer.
// Latency: n/a (package only); backpressure: n/a.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPACT,
        ST_EVAL,
        ST_DONE
    } state_t;

    localparam int          DEF_WIDTH = 16;
    localparam logic [15:0] DEF_POLY  = 16'h002D;
    localparam int          CNT_W     = 16;

endpackage

// File: rtl/bist_misr_reg.sv
// Galois-form MISR register with load/step/hold control; load+step steps from INIT_VALUE.
// Latency: 1 cycle per step; backpressure: none, steps whenever step_i is high.
module bist_misr_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] cut_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] base;

    always_comb begin
        base  = load_i ? INIT_VALUE : sig_q;
        sig_d = base;
        if (step_i) begin
            sig_d = {base[WIDTH-2:0], 1'b0} ^ (base[WIDTH-1] ? POLY : '0) ^ cut_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= INIT_VALUE;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST response analyzer: compacts CUT_OUT into a MISR and registers a PASS/FAIL verdict.
// Verdict 2 cycles after FINISH; no backpressure. BIST_MISR_COUNT_EN adds PAT_COUNT check.
module bist_misr_analyzer
    import bist_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter logic [WIDTH-1:0] GOLDEN     = '0,
    parameter int unsigned      EXP_COUNT  = 900
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             RUNNING,
    input  logic             OUT,
    input  logic             FINISH,
    input  logic [WIDTH-1:0] CUT_OUT,
    output logic [WIDTH-1:0] SIGNATURE,
    output logic             DONE,
    output logic             PASS,
    output logic             FAIL
`ifdef BIST_MISR_COUNT_EN
    ,
    output logic [CNT_W-1:0] PAT_COUNT
`endif
);

    state_t state_q;
    logic   running_q;
    logic   done_q;
    logic   pass_q;
    logic   fail_q;
    logic   run_start;
    logic   misr_step;
    logic   verdict_ok;

    // A rising RUNNING during the single EVAL cycle is deliberately dropped.
    assign run_start = RUNNING && !running_q && (state_q != ST_EVAL);
    assign misr_step = OUT && (run_start || (state_q == ST_COMPACT));

    bist_misr_reg #(
        .WIDTH      (WIDTH),
        .POLY       (POLY),
        .INIT_VALUE (INIT_VALUE)
    ) u_misr (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .load_i (run_start),
        .step_i (misr_step),
        .cut_i  (CUT_OUT),
        .sig_o  (SIGNATURE)
    );

`ifdef BIST_MISR_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (run_start) begin
            cnt_q <= OUT ? CNT_W'(1) : '0;
        end else if (misr_step && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign PAT_COUNT  = cnt_q;
    assign verdict_ok = (SIGNATURE == GOLDEN) && (cnt_q == CNT_W'(EXP_COUNT));
`else
    assign verdict_ok = (SIGNATURE == GOLDEN);
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            running_q <= RUNNING;
            if (run_start) begin
                state_q <= ST_COMPACT;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
                fail_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_COMPACT: begin
                        if (FINISH) begin
                            state_q <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        pass_q  <= verdict_ok;
                        fail_q  <= !verdict_ok;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign DONE = done_q;
    assign PASS = pass_q;
    assign FAIL = fail_q;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Self-checking bench for bist_misr_analyzer (WIDTH=4, POLY=3, GOLDEN=3).
module tb_bist_misr_analyzer;

    localparam logic [3:0] P_POLY = 4'h3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       running;
    logic       out_v;
    logic       finish;
    logic [3:0] cut;
    logic [3:0] sig;
    logic       done;
    logic       pass;
    logic       fail;
`ifdef BIST_MISR_COUNT_EN
    logic [15:0] pat_count;
`endif

    bist_misr_analyzer #(
        .WIDTH      (4),
        .POLY       (P_POLY),
        .INIT_VALUE (4'h0),
        .GOLDEN     (4'h3),
        .EXP_COUNT  (900)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .RUNNING   (running),
        .OUT       (out_v),
        .FINISH    (finish),
        .CUT_OUT   (cut),
        .SIGNATURE (sig),
        .DONE      (done),
        .PASS      (pass),
        .FAIL      (fail)
`ifdef BIST_MISR_COUNT_EN
        ,
        .PAT_COUNT (pat_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] model;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       run;
        logic       out;
        logic       fin;
        logic [3:0] cut;
        logic [3:0] sig;
        logic       done;
        logic       pass;
        logic       fail;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic verdict(input string tag, input logic d, input logic p, input logic f);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_pass"}, 32'(pass), 32'(p));
        chk({tag, "_fail"}, 32'(fail), 32'(f));
    endtask

    function automatic logic [3:0] mstep(input logic [3:0] s, input logic [3:0] c);
        logic [3:0] r;
        r = {s[2:0], 1'b0};
        if (s[3]) r = r ^ P_POLY;
        return r ^ c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Caller guarantees RUNNING was low on the previous edge.
    task automatic start_run(input string tag);
        running = 1'b1;
        out_v   = 1'b0;
        finish  = 1'b0;
        cyc();
        model = 4'h0;
        chk({tag, "_start_sig"}, 32'(sig), 32'h0);
        verdict({tag, "_start"}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vec(input logic run, input logic [3:0] c, input logic fin);
        running = run;
        out_v   = 1'b1;
        cut     = c;
        finish  = fin;
        model   = mstep(model, c);
        exp_q.push_back(model);
        cyc();
        out_v  = 1'b0;
        finish = 1'b0;
        chk("sb_sig", 32'(sig), 32'(exp_q.pop_front()));
    endtask

    task automatic finish_run(input string tag);
        running = 1'b0;
        out_v   = 1'b0;
        finish  = 1'b1;
        cyc();
        finish = 1'b0;
        chk({tag, "_eval_done"}, 32'(done), 32'h0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        running = 1'b0;
        out_v   = 1'b0;
        finish  = 1'b0;
        cut     = 4'h0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_sig", 32'(sig), 32'h0);
        verdict("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // FINISH and OUT in IDLE must be ignored.
        finish = 1'b1;
        out_v  = 1'b1;
        cut    = 4'h5;
        cyc();
        finish = 1'b0;
        out_v  = 1'b0;
        cyc();
        cyc();
        chk("idle_sig", 32'(sig), 32'h0);
        verdict("idle_finish", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            running = tbl[i].run;
            out_v   = tbl[i].out;
            finish  = tbl[i].fin;
            cut     = tbl[i].cut;
            cyc();
            chk($sformatf("kat%0d_sig", i), 32'(sig), 32'(tbl[i].sig));
            verdict($sformatf("kat%0d", i), tbl[i].done, tbl[i].pass, tbl[i].fail);
        end

        for (int i = 0; i < 50; i++) begin
            running = 1'b0;
            finish  = (i % 5 == 0);
            out_v   = 1'b1;
            cut     = 4'($urandom_range(0, 15));
            cyc();
            chk("hold_sig", 32'(sig), 32'h3);
            verdict("hold", 1'b1, 1'b1, 1'b0);
        end
        out_v  = 1'b0;
        finish = 1'b0;

        start_run("fail");
        vec(1'b1, 4'h1, 1'b0);
        vec(1'b1, 4'h4, 1'b0);
        vec(1'b1, 4'h0, 1'b0);
        vec(1'b1, 4'h0, 1'b0);
        vec(1'b1, 4'h0, 1'b0);
        finish_run("fail");
        verdict("fail_end", 1'b1, 1'b0, 1'b1);
        chk("fail_sig", 32'(sig), 32'h5);

        start_run("restart");
        vec(1'b1, 4'h1, 1'b0);
        vec(1'b1, 4'h0, 1'b0);
        vec(1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            running = 1'b0;
            out_v   = 1'b0;
            cyc();
            chk("gap_sig", 32'(sig), 32'h4);
        end
        vec(1'b0, 4'h0, 1'b0);
        vec(1'b0, 4'h0, 1'b1);
        chk("simul_eval_done", 32'(done), 32'h0);
        cyc();
        verdict("simul", 1'b1, 1'b1, 1'b0);
        chk("simul_sig", 32'(sig), 32'h3);

        // Asynchronous reset while holding a PASS verdict.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done_sig", 32'(sig), 32'h0);
        verdict("rst_done", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        out_v   = 1'b1;
        cut     = 4'h7;
        running = 1'b0;
        cyc();
        out_v = 1'b0;
        chk("post_rst_idle_sig", 32'(sig), 32'h0);

        start_run("midrun");
        vec(1'b1, 4'h1, 1'b0);
        vec(1'b1, 4'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_compact_sig", 32'(sig), 32'h0);
        verdict("rst_compact", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        running = 1'b0;
        cyc();

`ifdef BIST_MISR_COUNT_EN
        for (int n = 899; n <= 900; n++) begin
            logic [3:0] c;
            start_run("cnt");
            for (int j = 0; j < n - 1; j++) begin
                vec(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            end
            c = 4'h3 ^ mstep(model, 4'h0);
            vec(1'b1, c, 1'b0);
            chk("cnt_sig", 32'(sig), 32'h3);
            finish_run("cnt");
            chk("cnt_pat_count", 32'(pat_count), 32'(n));
            verdict($sformatf("cnt%0d", n), 1'b1, (n == 900), (n != 900));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bist_misr_analyzer.md
# bist_misr_analyzer

Output-response analyzer for the BIST loop, directly downstream of the BIST controller. It compacts the circuit-under-test response vectors into a multiple-input signature register (MISR) while the controller reports a running test. When the controller pulses FINISH, the block compares the final signature against a golden value and holds a registered PASS/FAIL verdict until the next run starts.

## Interface
Parameters:
- WIDTH, 16: CUT response and signature width, 2..32.
- POLY, 16'h002D: feedback tap mask (Galois form, x^WIDTH implied), WIDTH bits.
- INIT_VALUE, 0: MISR value loaded at run start and on reset.
- GOLDEN, 16'h0000: expected final signature. Set by the integrator per CUT.
- EXP_COUNT, 900: expected number of compacted vectors. Only used with BIST_MISR_COUNT_EN.

Ports:
- CLK, input, 1: single clock, rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- RUNNING, input, 1: controller test-active flag.
- OUT, input, 1: controller vector-valid strobe. CUT_OUT is compacted only when OUT=1.
- FINISH, input, 1: controller one-cycle end-of-test pulse.
- CUT_OUT, input, WIDTH: CUT response vector.
- SIGNATURE, output, WIDTH: current MISR contents.
- DONE, output, 1: verdict valid.
- PASS, output, 1: signature (and count, if enabled) matched.
- FAIL, output, 1: mismatch. PASS and FAIL are never both 1.
- PAT_COUNT, output, 16: compacted-vector count. Present only with BIST_MISR_COUNT_EN.

## Operation
- The FSM has four states: IDLE, COMPACT, EVAL, DONE. A registered copy of RUNNING (running_q) is used for edge detection.
- Run start is the condition RUNNING=1 && running_q=0. It is honoured in IDLE, COMPACT and DONE.
  - Next state is COMPACT.
  - PASS, FAIL and DONE clear to 0.
  - The MISR loads INIT_VALUE. If OUT=1 in the same cycle, it loads step(INIT_VALUE, CUT_OUT) instead.
- MISR step: next = {misr[WIDTH-2:0],1'b0} ^ (misr[WIDTH-1] ? POLY : 0) ^ CUT_OUT.
- COMPACT:
  - Each cycle with OUT=1 the MISR steps. With OUT=0 it holds.
  - RUNNING dropping without FINISH does not leave COMPACT. The signature holds.
  - FINISH=1 moves the FSM to EVAL. A vector with OUT=1 in the same cycle is compacted first.
- EVAL lasts one cycle:
  - PASS <= (SIGNATURE == GOLDEN); FAIL <= the inverse.
  - Next state is DONE.
- DONE:
  - DONE=1; PASS and FAIL hold.
  - FINISH is ignored.
  - A new run start re-enters COMPACT.
- FINISH in IDLE is ignored. OUT while not in COMPACT (other than in the run-start cycle) is ignored.
- Reset (asynchronous, at any time, including mid-run) sets:
  - state = IDLE;
  - SIGNATURE = INIT_VALUE;
  - PASS = FAIL = DONE = 0;
  - running_q = 0;
  - PAT_COUNT = 0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- SIGNATURE reflects a vector one cycle after the edge that samples OUT=1.
- FINISH sampled at edge k gives EVAL after edge k. The verdict and DONE=1 are visible after edge k+1, i.e. a 2-cycle latency from FINISH.
- The verdict is cleared on the edge that samples the run-start condition.

## Configuration
- Macro: BIST_MISR_COUNT_EN.
- With BIST_MISR_COUNT_EN defined:
  - A 16-bit PAT_COUNT increments on every compacted vector and saturates at 16'hFFFF.
  - PAT_COUNT clears on run start.
  - EVAL requires both SIGNATURE==GOLDEN and PAT_COUNT==EXP_COUNT for PASS.
  - The PAT_COUNT port exists.
- Without the macro, there is no counter and no PAT_COUNT port. The verdict depends on the signature only.

## Structure
- Shared package bist_pkg holds:
  - the FSM state typedef (IDLE, COMPACT, EVAL, DONE);
  - default WIDTH and POLY constants;
  - the 16-bit count width constant.
- One sub-module, bist_misr_reg, holds the WIDTH-bit register with load/step/hold control and the Galois feedback. The FSM, verdict and counter stay in bist_misr_analyzer.

## Test plan
- Reset behaviour. Configure WIDTH=4, POLY=4'h3, INIT=0. Assert RESET_N=0 during COMPACT -> SIGNATURE=0, DONE=PASS=FAIL=0, state IDLE immediately, without waiting for a clock edge.
- Known-answer sequence. Same config. Run start, then OUT=1 with CUT_OUT=1,0,0,0,0 -> SIGNATURE goes 1, 2, 4, 8, 3.
- Passing run. GOLDEN=4'h3, then FINISH pulse -> DONE=1 and PASS=1 exactly 2 cycles after FINISH. Both hold for 50 cycles while FINISH pulses again.
- Failing run. Flip one CUT_OUT bit in the middle of the run with GOLDEN=4'h3 -> FAIL=1, PASS=0. A new RUNNING rising edge clears both on that edge.
- Gap and simultaneous events. RUNNING drops for 3 cycles inside COMPACT -> SIGNATURE holds. OUT=1 together with FINISH -> that vector is included in the compared signature.
- BIST_MISR_COUNT_EN count check. Correct signature with 899 vectors and EXP_COUNT=900 -> FAIL=1. With 900 vectors -> PASS=1 and PAT_COUNT=900.
